// File: rtl/serial_sub.sv
//==============================================================================
// serial_sub : bit-serial W-bit subtractor (one full-subtractor cell plus a
//              borrow flop). SERIAL_SUB_FLAGS_EN adds a registered zero flag.
// Revision   : 1.0
//==============================================================================
`default_nettype none

module serial_sub #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] dif,
    output logic         bor
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic         zero
`endif
);

    localparam int            CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_sa;
    logic [W-1:0]  r_sb;
    logic [W-1:0]  r_res;
    logic          r_br;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [W-1:0]  r_dif;
    logic          r_bor;

    logic          w_d;
    logic          w_bo;
    logic          w_last;
    logic          w_load;
    logic          w_shift;
    logic          w_finish;
    logic [W-1:0]  w_res_nxt;

    // Full-subtractor cell on the current LSBs and the carried borrow
    assign w_d    = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_bo   = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_last = (r_cnt == C_LAST);

    generate
        if (W == 1) begin : g_res_w1
            assign w_res_nxt = w_d;
        end else begin : g_res_wn
            assign w_res_nxt = {w_d, r_res[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_dif  <= '0;
            r_bor  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_sa  <= a;
                r_sb  <= b;
                r_br  <= bin;
                r_cnt <= '0;
            end else if (w_shift) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_res <= w_res_nxt;
                r_br  <= w_bo;
                r_cnt <= r_cnt + C_ONE;
                if (w_finish) begin
                    r_dif <= w_res_nxt;
                    r_bor <= w_bo;
                end
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_finish) begin
            r_zero <= (w_res_nxt == '0);
        end
    end

    assign zero = r_zero;
`endif

    // Busy is exactly the SHIFT state, so it needs no flop of its own
    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign dif  = r_dif;
    assign bor  = r_bor;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
//==============================================================================
// tb_serial_sub : directed bench for serial_sub (W=4) with a cycle model.
// Revision      : 1.0
//==============================================================================
`default_nettype none

module tb_serial_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] dif;
    logic         bor;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dif   (dif),
        .bor   (bor)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero)
`endif
    );

    always #5 clk = ~clk;

    // Transaction-level model: result is plain arithmetic, shown W edges later
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_dif  = '0;
    logic         m_bor  = 1'b0;
    logic         m_zero = 1'b0;
    logic [W-1:0] m_pd   = '0;
    logic         m_pb   = 1'b0;
    int           m_left = 0;

    always @(posedge clk or posedge rst) begin
        int t;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dif  = '0;
            m_bor  = 1'b0;
            m_zero = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dif  = m_pd;
                    m_bor  = m_pb;
                    m_zero = (m_pd == '0);
                end
            end else if (start) begin
                t      = int'(a) - int'(b) - int'(bin);
                m_pd   = W'(t & ((1 << W) - 1));
                m_pb   = (t < 0);
                m_busy = 1'b1;
                m_left = W;
            end
        end
    end

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_tests++;
                if (busy !== m_busy || done !== m_done || dif !== m_dif || bor !== m_bor) begin
                    n_fail++;
                    $display("FAIL cycle@%0t: busy=%b done=%b dif=%0d bor=%b required busy=%b done=%b dif=%0d bor=%b",
                             $time, busy, done, dif, bor, m_busy, m_done, m_dif, m_bor);
                end
`ifdef SERIAL_SUB_FLAGS_EN
                n_tests++;
                if (zero !== m_zero) begin
                    n_fail++;
                    $display("FAIL zero@%0t: got %b required %b", $time, zero, m_zero);
                end
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Returns the number of negedges from start release to done (W+1 expected)
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, output int lat);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        bin   = ibin;
        @(negedge clk);
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        bin   = ~ibin;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #3 rst = 1'b1;
        fork
            compare_loop();
        join_none
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic op, latency and hold
        run_op(4'd9, 4'd3, 1'b0, lat);
        chk("lat_9_3", lat, W + 1);
        chk("dif_9_3", dif, 6);
        chk("bor_9_3", bor, 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("dif_hold", dif, 6);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dif", dif, 0);
        chk("rst_bor", bor, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd3, 4'd9, 1'b1, lat);
        chk("dif_3_9_1", dif, 9);
        chk("bor_3_9_1", bor, 1);
        run_op(4'd0, 4'd0, 1'b1, lat);
        chk("dif_wrap", dif, 15);
        chk("bor_wrap", bor, 1);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignore_busy_dif", dif, 6);
        chk("ignore_busy_bor", bor, 0);

        // Start presented in the done cycle is accepted at the next edge
        start = 1'b1; a = 4'd6; b = 4'd5; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_lat", lat, W + 1);
        chk("b2b_dif", dif, 1);

        // Reset on the second shift edge
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_dif", dif, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_op(4'd9, 4'd3, 1'b0, lat);
        chk("after_abort_lat", lat, W + 1);
        chk("after_abort_dif", dif, 6);

        run_op(4'd5, 4'd5, 1'b0, lat);
        chk("dif_5_5", dif, 0);
        chk("bor_5_5", bor, 0);
`ifdef SERIAL_SUB_FLAGS_EN
        chk("zero_5_5", zero, 1);
`endif
        run_op(4'd6, 4'd5, 1'b0, lat);
        chk("dif_6_5", dif, 1);
`ifdef SERIAL_SUB_FLAGS_EN
        chk("zero_6_5", zero, 0);
`endif

        // Exhaustive sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int z = 0; z < 2; z++) begin
                    run_op(4'(x), 4'(y), 1'(z), lat);
                    chk("sweep_dif", dif, (x - y - z) & 15);
                    chk("sweep_bor", bor, (x < y + z) ? 1 : 0);
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
